// File: rtl/vx_jal_overload_seq_pkg.sv
// Shared types for the JAL-overload window sequencer: FSM states and the CSR return record.
// Combinational-only definitions; no latency or backpressure of their own.
package VX_gpu_pkg;

  localparam int JAL_OVL_WARP_CNT = 4;
  localparam int JAL_OVL_XLEN     = 32;
  localparam int JAL_OVL_WID_W    = (JAL_OVL_WARP_CNT > 1) ? $clog2(JAL_OVL_WARP_CNT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } jal_ovl_state_t;

  typedef struct packed {
    logic [JAL_OVL_WID_W-1:0] wid;
    logic [JAL_OVL_XLEN-1:0]  pc;
  } jal_ovl_ret_t;

endpackage

// File: rtl/vx_jal_overload_seq_rr_pick.sv
// vx_rr_pick: round-robin pick over a request mask, searching upward from ptr with wrap.
// Purely combinational, zero latency; no backpressure of its own.
module vx_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_vld && req[idx]) begin
        gnt_vld      = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = W'(idx);
      end
    end
  end

endmodule

// File: rtl/vx_jal_overload_seq.sv
// JAL-overload window sequencer: steers RHA onto each warp's first JAL commit, drains true PCs to CSR.
// ovl_sel same cycle; hit -> ret_valid in 2 cycles; ret held while !ret_ready. Optional watchdog: JAL_OVL_TIMEOUT_EN.
module vx_jal_overload_seq
  import VX_gpu_pkg::*;
#(
  parameter int WARP_CNT       = JAL_OVL_WARP_CNT,
  parameter int ISSUE_CNT      = 4,
  parameter int XLEN           = JAL_OVL_XLEN,
  parameter int WID_W          = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm_valid,
  input  logic [XLEN-1:0]           ret_handler_addr,
  output logic                      active,
  input  logic [ISSUE_CNT-1:0]      br_valid,
  input  logic [ISSUE_CNT*WID_W-1:0] br_wid,
  input  logic [ISSUE_CNT-1:0]      cm_valid,
  input  logic [ISSUE_CNT-1:0]      cm_ready,
  input  logic [ISSUE_CNT*XLEN-1:0] cm_link,
  output logic [ISSUE_CNT-1:0]      ovl_sel,
  output logic [XLEN-1:0]           ovl_data,
  output logic [WARP_CNT-1:0]       hit_mask,
  output logic                      ret_valid,
  input  logic                      ret_ready,
  output logic [WID_W-1:0]          ret_wid,
  output logic [XLEN-1:0]           ret_pc,
  output logic                      done
`ifdef JAL_OVL_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  jal_ovl_state_t state, state_nxt;

  logic [XLEN-1:0]      rha_q;
  logic [WARP_CNT-1:0]  hit_q, pend_q, hit_set;
  logic [XLEN-1:0]      cap_q [WARP_CNT];
  logic [WID_W-1:0]     wid [ISSUE_CNT];
  logic [ISSUE_CNT-1:0] cand, q;
  logic [WID_W-1:0]     rr_ptr;
  logic [WARP_CNT-1:0]  gnt;
  logic [WID_W-1:0]     gnt_idx;
  logic                 gnt_vld, load, out_vld, all_hit, arm_acc;
  jal_ovl_ret_t         out_q;

  assign arm_acc = (state == IDLE) && arm_valid;
  assign all_hit = &(hit_q | hit_set);

  // Duplicate wids in one cycle: only the lowest qualifying block takes the substitution.
  always_comb begin
    for (int i = 0; i < ISSUE_CNT; i++) begin
      wid[i]  = br_wid[i*WID_W +: WID_W];
      cand[i] = active & br_valid[i] & cm_valid[i] & cm_ready[i]
              & (int'(wid[i]) < WARP_CNT) & !hit_q[wid[i]];
    end
    q = cand;
    for (int i = 1; i < ISSUE_CNT; i++)
      for (int j = 0; j < i; j++)
        if (cand[j] && (wid[j] == wid[i])) q[i] = 1'b0;
    hit_set = '0;
    for (int i = 0; i < ISSUE_CNT; i++)
      if (q[i]) hit_set[wid[i]] = 1'b1;
  end

  assign ovl_sel  = q;
  assign ovl_data = rha_q;
  assign hit_mask = hit_q;

`ifdef JAL_OVL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || arm_acc) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (state == ARMED) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_hit && !all_hit) timeout_err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (arm_valid) state_nxt = ARMED;
      ARMED: begin
        if (all_hit) state_nxt = DRAIN;
`ifdef JAL_OVL_TIMEOUT_EN
        else if (to_hit) state_nxt = DRAIN;
`endif
      end
      DRAIN: if ((pend_q == '0) && !out_vld) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    active = (state == ARMED);
    done   = (state == DONE);
  end

  vx_rr_pick #(.N(WARP_CNT), .W(WID_W)) u_rr_pick (
    .req     (pend_q),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // One-entry output stage refills on the same edge it hands off, giving one write per cycle.
  assign load = gnt_vld && (!out_vld || ret_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      rha_q   <= '0;
      hit_q   <= '0;
      pend_q  <= '0;
      rr_ptr  <= '0;
      out_vld <= 1'b0;
      out_q   <= '0;
      for (int w = 0; w < WARP_CNT; w++) cap_q[w] <= '0;
    end else begin
      if (arm_acc) begin
        rha_q <= ret_handler_addr;
        hit_q <= '0;
      end else begin
        hit_q <= hit_q | hit_set;
      end
      pend_q <= (pend_q & ~(load ? gnt : '0)) | hit_set;
      for (int i = 0; i < ISSUE_CNT; i++)
        if (q[i]) cap_q[wid[i]] <= cm_link[i*XLEN +: XLEN];
      if (load) begin
        out_vld   <= 1'b1;
        out_q.wid <= gnt_idx;
        out_q.pc  <= cap_q[gnt_idx];
        rr_ptr    <= (gnt_idx == WID_W'(WARP_CNT - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (ret_ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign ret_valid = out_vld;
  assign ret_wid   = out_q.wid;
  assign ret_pc    = out_q.pc;

endmodule

// File: tb/tb_vx_jal_overload_seq.sv
// Directed bench for vx_jal_overload_seq; expected CSR writes go into a scoreboard queue
// and a negedge monitor checks every handshake and every stalled cycle.
module tb_vx_jal_overload_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm_valid = 1'b0;
  logic [31:0] ret_handler_addr = '0;
  logic        active;
  logic [3:0]  br_valid = '0;
  logic [7:0]  br_wid = '0;
  logic [3:0]  cm_valid = '0;
  logic [3:0]  cm_ready = '0;
  logic [127:0] cm_link = '0;
  logic [3:0]  ovl_sel;
  logic [31:0] ovl_data;
  logic [3:0]  hit_mask;
  logic        ret_valid;
  logic        ret_ready = 1'b1;
  logic [1:0]  ret_wid;
  logic [31:0] ret_pc;
  logic        done;
`ifdef JAL_OVL_TIMEOUT_EN
  logic        timeout_err;
`endif

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [33:0] exp_q[$];
  logic        stalled = 1'b0;
  logic [1:0]  st_wid;
  logic [31:0] st_pc;

  always #5 clk = ~clk;

  vx_jal_overload_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .arm_valid        (arm_valid),
    .ret_handler_addr (ret_handler_addr),
    .active           (active),
    .br_valid         (br_valid),
    .br_wid           (br_wid),
    .cm_valid         (cm_valid),
    .cm_ready         (cm_ready),
    .cm_link          (cm_link),
    .ovl_sel          (ovl_sel),
    .ovl_data         (ovl_data),
    .hit_mask         (hit_mask),
    .ret_valid        (ret_valid),
    .ret_ready        (ret_ready),
    .ret_wid          (ret_wid),
    .ret_pc           (ret_pc),
    .done             (done)
`ifdef JAL_OVL_TIMEOUT_EN
    ,
    .timeout_err      (timeout_err)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr();
    br_valid = '0;
    cm_valid = '0;
    cm_ready = '0;
    br_wid   = '0;
    cm_link  = '0;
  endtask

  task automatic jal(input int b, input int w, input logic [31:0] link, input logic rdy);
    br_valid[b]          = 1'b1;
    cm_valid[b]          = 1'b1;
    cm_ready[b]          = rdy;
    br_wid[b*2 +: 2]     = w[1:0];
    cm_link[b*32 +: 32]  = link;
  endtask

  task automatic push(input int w, input logic [31:0] pc);
    exp_q.push_back({w[1:0], pc});
  endtask

  task automatic arm(input logic [31:0] rha);
    cyc();
    arm_valid        = 1'b1;
    ret_handler_addr = rha;
    sample();
    cyc();
    arm_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cyc();
      sample();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 64'(found), 64'h1);
    cyc();
    sample();
    chk({name, "_done_one_cycle"}, 64'(done), 64'h0);
    chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_active"},    64'(active),    64'h0);
    chk({name, "_ovl_sel"},   64'(ovl_sel),   64'h0);
    chk({name, "_ovl_data"},  64'(ovl_data),  64'h0);
    chk({name, "_hit_mask"},  64'(hit_mask),  64'h0);
    chk({name, "_ret_valid"}, 64'(ret_valid), 64'h0);
    chk({name, "_ret_wid"},   64'(ret_wid),   64'h0);
    chk({name, "_ret_pc"},    64'(ret_pc),    64'h0);
    chk({name, "_done"},      64'(done),      64'h0);
  endtask

  // Scoreboard monitor: pops on each handshake, enforces hold while stalled.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", 64'({ret_valid, ret_wid, ret_pc}), 64'({1'b1, st_wid, st_pc}));
      if (ret_valid && ret_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ret_unexpected: got wid %0d pc 0x%0h, expected no write", ret_wid, ret_pc);
        end else begin
          chk("ret_write", 64'({ret_wid, ret_pc}), 64'(exp_q.pop_front()));
        end
      end
      stalled = ret_valid && !ret_ready;
      st_wid  = ret_wid;
      st_pc   = ret_pc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) cyc();
    sample();
    chk_zero("reset");
    cyc();
    reset = 1'b0;

    // All four warps in one cycle, latency and back-to-back drain
    arm(32'h8000_0100);
    jal(0, 0, 32'h100, 1'b1);
    jal(1, 1, 32'h204, 1'b1);
    jal(2, 2, 32'h308, 1'b1);
    jal(3, 3, 32'h40C, 1'b1);
    push(0, 32'h100); push(1, 32'h204); push(2, 32'h308); push(3, 32'h40C);
    sample();
    chk("t1_active", 64'(active), 64'h1);
    chk("t1_ovl_data", 64'(ovl_data), 64'h8000_0100);
    chk("t1_ovl_sel", 64'(ovl_sel), 64'hF);
    cyc();
    clr();
    sample();
    chk("t1_hit_mask", 64'(hit_mask), 64'hF);
    chk("t1_drain_inactive", 64'(active), 64'h0);
    chk("t1_ret_not_yet", 64'(ret_valid), 64'h0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      sample();
      chk("t1_ret_valid_b2b", 64'(ret_valid), 64'h1);
      chk("t1_ret_wid_order", 64'(ret_wid), 64'(k));
    end
    wait_done("t1");
    chk("t1_done_count", 64'(done_cnt), 64'h1);
    chk("t1_ovl_data_hold", 64'(ovl_data), 64'h8000_0100);
    chk("t1_hit_mask_hold", 64'(hit_mask), 64'hF);

    // Stalled commit, repeat JAL from a hit warp, duplicate wid across blocks
    arm(32'h0000_1000);
    for (int r = 0; r < 3; r++) begin
      jal(0, 2, 32'h2222, 1'b0);
      sample();
      chk("t2_not_ready", 64'(ovl_sel), 64'h0);
      cyc();
    end
    jal(0, 2, 32'h2222, 1'b1);
    push(2, 32'h2222);
    sample();
    chk("t2_fire", 64'(ovl_sel), 64'h1);
    cyc();
    clr();
    sample();
    chk("t2_hit_mask", 64'(hit_mask), 64'h4);
    cyc();
    jal(1, 2, 32'h3333, 1'b1);
    sample();
    chk("t2_second_jal", 64'(ovl_sel), 64'h0);
    cyc();
    clr();
    jal(1, 1, 32'hAAA1, 1'b1);
    jal(3, 1, 32'hBBB3, 1'b1);
    push(1, 32'hAAA1);
    sample();
    chk("t3_dup_wid", 64'(ovl_sel), 64'h2);
    cyc();
    clr();
    sample();
    chk("t3_hit_mask", 64'(hit_mask), 64'h6);
    cyc();
    jal(0, 0, 32'h5550, 1'b1);
    jal(2, 3, 32'h5553, 1'b1);
    push(3, 32'h5553); push(0, 32'h5550);
    sample();
    chk("t3_finish_sel", 64'(ovl_sel), 64'h5);
    cyc();
    clr();
    wait_done("t3");
    chk("t3_done_count", 64'(done_cnt), 64'h2);

    // CSR port stalled five cycles; round-robin resumes from pointer 1
    ret_ready = 1'b0;
    arm(32'h0000_2000);
    jal(0, 2, 32'h4002, 1'b1);
    jal(1, 0, 32'h4000, 1'b1);
    jal(2, 3, 32'h4003, 1'b1);
    jal(3, 1, 32'h4001, 1'b1);
    push(1, 32'h4001); push(2, 32'h4002); push(3, 32'h4003); push(0, 32'h4000);
    sample();
    chk("t4_ovl_sel", 64'(ovl_sel), 64'hF);
    cyc();
    clr();
    sample();
    cyc();
    sample();
    chk("t4_stall_valid", 64'(ret_valid), 64'h1);
    chk("t4_stall_wid", 64'(ret_wid), 64'h1);
    chk("t4_stall_pc", 64'(ret_pc), 64'h4001);
    repeat (5) begin
      cyc();
      sample();
    end
    cyc();
    ret_ready = 1'b1;
    wait_done("t4");
    chk("t4_done_count", 64'(done_cnt), 64'h3);

    // Reset mid-window abandons everything
    ret_ready = 1'b0;
    arm(32'h0000_3000);
    jal(0, 0, 32'h6000, 1'b1);
    jal(1, 1, 32'h6001, 1'b1);
    sample();
    chk("t5_ovl_sel", 64'(ovl_sel), 64'h3);
    cyc();
    clr();
    sample();
    chk("t5_hit_mask", 64'(hit_mask), 64'h3);
    chk("t5_active", 64'(active), 64'h1);
    cyc();
    reset = 1'b1;
    sample();
    cyc();
    reset = 1'b0;
    ret_ready = 1'b1;
    sample();
    chk_zero("t5_after_reset");
    repeat (4) begin
      cyc();
      sample();
    end
    chk("t5_no_done", 64'(done_cnt), 64'h3);
    arm(32'hC0DE_0000);
    jal(0, 0, 32'h7000, 1'b1);
    jal(1, 1, 32'h7004, 1'b1);
    jal(2, 2, 32'h7008, 1'b1);
    jal(3, 3, 32'h700C, 1'b1);
    push(0, 32'h7000); push(1, 32'h7004); push(2, 32'h7008); push(3, 32'h700C);
    sample();
    chk("t5_rearm_sel", 64'(ovl_sel), 64'hF);
    chk("t5_rearm_data", 64'(ovl_data), 64'hC0DE_0000);
    cyc();
    clr();
    wait_done("t5");
    chk("t5_done_count", 64'(done_cnt), 64'h4);

`ifdef JAL_OVL_TIMEOUT_EN
    // Watchdog forces drain with only warps 0 and 1 hit
    begin
      int act_cycles;
      act_cycles = 0;
      arm(32'h0000_4000);
      jal(0, 0, 32'h8000, 1'b1);
      jal(1, 1, 32'h8004, 1'b1);
      push(0, 32'h8000); push(1, 32'h8004);
      for (int n = 0; n < 40; n++) begin
        sample();
        if (!active) break;
        act_cycles++;
        cyc();
        clr();
      end
      chk("t6_active_cycles", 64'(act_cycles), 64'd16);
      chk("t6_timeout_err", 64'(timeout_err), 64'h1);
      chk("t6_hit_mask", 64'(hit_mask), 64'h3);
      wait_done("t6");
      chk("t6_done_count", 64'(done_cnt), 64'h5);
      chk("t6_err_sticky", 64'(timeout_err), 64'h1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
